iotdf_ctrl: RTL and testbench
=============================

IOTDF_CTRL -- requirements
Module: iotdf_ctrl

Interface
REQ-001 SHALL have parameters: BYTES_PER_WORD, default 16, bytes per 128-bit word; WORDS_PER_ROUND, default 8, words per round.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_en  in  1  host byte strobe; one byte presented per cycle when high.
REQ-005 SHALL have port fn_sel  in  3  function code, 1..7.
REQ-006 SHALL have port dp_match  in  1  datapath flag: current word passes the range test (fn 4/5).
REQ-007 SHALL have port dp_peak  in  1  datapath flag: the round result exceeds the stored peak (fn 6/7).
REQ-008 SHALL have port byte_we  out  1  shift the current byte into the word register.
REQ-009 SHALL have port byte_cnt  out  4  index of the next byte within the word.
REQ-010 SHALL have port word_cnt  out  3  index of the word within the round.
REQ-011 SHALL have port acc_load  out  1  load the accumulator (first word of a round).
REQ-012 SHALL have port dp_en  out  1  compare/accumulate the completed word.
REQ-013 SHALL have port fn_q  out  3  function latched for the current round.
REQ-014 SHALL have port busy  out  1  host must hold in_en low.
REQ-015 SHALL have port valid  out  1  iot_out is valid this cycle.

Function
REQ-016 SHALL implement the states IDLE, RECV, PROC and OUT.
REQ-017 In IDLE, in_en=1 SHALL latch fn_sel into fn_q, assert byte_we, set byte_cnt=1 and go to RECV.
REQ-018 In IDLE, fn_sel=0 with in_en=1 SHALL be ignored: no byte is counted and the state stays IDLE.
REQ-019 In RECV, in_en=1 SHALL assert byte_we combinationally and increment byte_cnt; in_en=0 SHALL hold all state.
REQ-020 Accepting byte 15 (byte_cnt=15 and in_en=1) SHALL wrap byte_cnt to 0 and go to PROC on the next edge.
REQ-021 PROC SHALL last exactly 1 cycle with busy=1 and dp_en=1; acc_load=1 only when word_cnt=0.
REQ-022 On exit from PROC, word_cnt SHALL increment modulo 8.
REQ-023 fn 4/5 (per-word), on exit from PROC: go to OUT if dp_match=1, else go to RECV.
REQ-024 fn 1,2,3,6,7 (per-round), on exit from PROC: go to OUT if word_cnt=7, else go to RECV.
REQ-025 fn 6/7 with dp_peak=0 at round end SHALL skip OUT and go to IDLE, except the first round after reset, which always outputs.
REQ-026 OUT SHALL last 1 cycle with valid=1 and busy=1, then go to IDLE if the round is complete, else to RECV.
REQ-027 fn_sel changes after the first byte of a round SHALL have no effect until the next IDLE entry.
REQ-028 in_en=1 while busy=1 SHALL be dropped: no byte_we, no counter change.
REQ-029 busy SHALL be registered and high exactly in PROC and OUT, so there is zero-cycle latency from the state.
REQ-030 Latency: 16th byte accepted at edge N; dp_en high in cycle N+1; valid high in cycle N+2.

Reset
REQ-031 rst low SHALL immediately force state=IDLE, byte_cnt=0, word_cnt=0, fn_q=0, busy=0, valid=0, dp_en=0, acc_load=0, and the first-round flag=1.
REQ-032 Reset mid-word or mid-round SHALL discard the partial data; no valid pulse follows.
REQ-033 Deassertion SHALL take effect at the next clk edge; in_en on that edge is accepted.

Structure
REQ-034 Function codes, the state encoding and the BYTES_PER_WORD/WORDS_PER_ROUND defaults SHALL reside in package iotdf_pkg.
REQ-035 The byte/word counters SHALL be one sub-module, iotdf_cnt, with the FSM in iotdf_ctrl.
REQ-036 The block SHALL contain no datapath registers; the 128-bit storage lives outside.

Verification
REQ-037 fn=1, 128 contiguous bytes -> 8 PROC cycles, acc_load only on the first; a single valid pulse 2 cycles after byte 128; then IDLE.
REQ-038 fn=4, 3 words with dp_match=1,0,1 -> valid after words 1 and 3 only; word_cnt=3 at the end.
REQ-039 in_en held high through PROC/OUT -> the dropped bytes are not counted; byte_cnt stays 0 until busy falls.
REQ-040 fn=6, round 1 dp_peak=0 -> valid; round 2 dp_peak=0 -> no valid; round 3 dp_peak=1 -> valid.
REQ-041 rst low at byte 9 of word 5 -> all outputs 0 the same cycle; the next 128 bytes produce exactly one valid.
REQ-042 fn_sel toggles 1->2 mid-round -> fn_q stays 1 through OUT; fn_q=2 after the next IDLE start.

Source files
------------

// File: rtl/iotdf_pkg.sv
// Shared definitions for the IOTDF control block: function codes, FSM states, sizing defaults.
package iotdf_pkg;

    localparam int unsigned BytesPerWordDef  = 16;
    localparam int unsigned WordsPerRoundDef = 8;

    typedef enum logic [2:0] {
        FnNone = 3'd0,
        FnRnd1 = 3'd1,
        FnRnd2 = 3'd2,
        FnRnd3 = 3'd3,
        FnWrd4 = 3'd4,
        FnWrd5 = 3'd5,
        FnPk6  = 3'd6,
        FnPk7  = 3'd7
    } fn_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StProc = 2'd2,
        StOut  = 2'd3
    } state_e;

    // Per-word functions report after every matching word instead of once per round.
    function automatic logic fn_per_word(input logic [2:0] fn);
        return (fn == FnWrd4) || (fn == FnWrd5);
    endfunction

    function automatic logic fn_peak(input logic [2:0] fn);
        return (fn == FnPk6) || (fn == FnPk7);
    endfunction

endpackage

// File: rtl/iotdf_cnt.sv
// Byte-within-word and word-within-round counters, both wrapping.
module iotdf_cnt
    import iotdf_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD  = BytesPerWordDef,
    parameter int unsigned WORDS_PER_ROUND = WordsPerRoundDef,
    localparam int unsigned BW = $clog2(BYTES_PER_WORD),
    localparam int unsigned WW = $clog2(WORDS_PER_ROUND)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_inc,
    input  logic          word_inc,
    output logic [BW-1:0] byte_cnt,
    output logic [WW-1:0] word_cnt,
    output logic          byte_last,
    output logic          word_last
);

    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;

    assign byte_last = (byte_cnt_q == BW'(BYTES_PER_WORD - 1));
    assign word_last = (word_cnt_q == WW'(WORDS_PER_ROUND - 1));

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        if (byte_inc) begin
            byte_cnt_d = byte_last ? '0 : byte_cnt_q + BW'(1);
        end
        if (word_inc) begin
            word_cnt_d = word_last ? '0 : word_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: rtl/iotdf_ctrl.sv
// Control FSM sequencing byte intake, per-word processing and result output for the IOTDF
// datapath; holds no data, only counters, the latched function and the first-round flag.
module iotdf_ctrl
    import iotdf_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD  = BytesPerWordDef,
    parameter int unsigned WORDS_PER_ROUND = WordsPerRoundDef,
    localparam int unsigned BW = $clog2(BYTES_PER_WORD),
    localparam int unsigned WW = $clog2(WORDS_PER_ROUND)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic [2:0]    fn_sel,
    input  logic          dp_match,
    input  logic          dp_peak,
    output logic          byte_we,
    output logic [BW-1:0] byte_cnt,
    output logic [WW-1:0] word_cnt,
    output logic          acc_load,
    output logic          dp_en,
    output logic [2:0]    fn_q,
    output logic          busy,
    output logic          valid
);

    state_e     state_q, state_d;
    logic [2:0] fn_lat_q, fn_lat_d;
    logic       first_q, first_d;
    logic       busy_q, busy_d;
    logic       accept;
    logic       byte_last, word_last;

    // A byte is taken only while idle with a real function code, or mid-word.
    assign accept = in_en &&
                    (((state_q == StIdle) && (fn_sel != 3'd0)) || (state_q == StRecv));

    iotdf_cnt #(
        .BYTES_PER_WORD  (BYTES_PER_WORD),
        .WORDS_PER_ROUND (WORDS_PER_ROUND)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .byte_inc  (accept),
        .word_inc  (state_q == StProc),
        .byte_cnt  (byte_cnt),
        .word_cnt  (word_cnt),
        .byte_last (byte_last),
        .word_last (word_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            fn_lat_q <= 3'd0;
            first_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fn_lat_q <= fn_lat_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fn_lat_d = fn_lat_q;
        first_d  = first_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    fn_lat_d = fn_sel;
                    state_d  = byte_last ? StProc : StRecv;
                end
            end
            StRecv: begin
                if (accept && byte_last) begin
                    state_d = StProc;
                end
            end
            StProc: begin
                if (word_last) begin
                    first_d = 1'b0;
                end
                if (fn_per_word(fn_lat_q)) begin
                    state_d = dp_match ? StOut : StRecv;
                end else if (!word_last) begin
                    state_d = StRecv;
                end else if (fn_peak(fn_lat_q) && !dp_peak && !first_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StOut;
                end
            end
            StOut: begin
                // word_cnt has already advanced, so zero means the round just closed.
                state_d = (word_cnt == '0) ? StIdle : StRecv;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StProc) || (state_d == StOut);
    end

    always_comb begin
        byte_we  = accept;
        dp_en    = (state_q == StProc);
        acc_load = (state_q == StProc) && (word_cnt == '0);
        valid    = (state_q == StOut);
    end

    assign busy = busy_q;
    assign fn_q = fn_lat_q;

endmodule

// File: tb/tb_iotdf_ctrl.sv
// Self-checking bench for iotdf_ctrl: event-level reference model, directed scenarios, random run.
module tb_iotdf_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_en = 1'b0;
    logic [2:0] fn_sel = 3'd0;
    logic       dp_match = 1'b0;
    logic       dp_peak = 1'b0;
    logic       byte_we, acc_load, dp_en, busy, valid;
    logic [3:0] byte_cnt;
    logic [2:0] word_cnt, fn_q;

    iotdf_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_en    (in_en),
        .fn_sel   (fn_sel),
        .dp_match (dp_match),
        .dp_peak  (dp_peak),
        .byte_we  (byte_we),
        .byte_cnt (byte_cnt),
        .word_cnt (word_cnt),
        .acc_load (acc_load),
        .dp_en    (dp_en),
        .fn_q     (fn_q),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_valid = 0, n_dp = 0, n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a round is 8 words of 16 bytes; after each word one processing cycle,
    // optionally followed by one output cycle.
    bit m_active, m_proc, m_out, m_first, m_re, m_go;
    int m_bcnt, m_wcnt, m_fn;

    function automatic bit per_word(input int f);
        return (f == 4) || (f == 5);
    endfunction

    function automatic bit exp_we();
        return in_en && !(m_proc || m_out) && (m_active || (fn_sel != 3'd0));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_proc = 0; m_out = 0; m_first = 1;
            m_bcnt = 0; m_wcnt = 0; m_fn = 0;
        end else if (m_proc) begin
            m_re = (m_wcnt == 7);
            m_wcnt = (m_wcnt + 1) % 8;
            if (per_word(m_fn)) m_go = dp_match;
            else m_go = m_re && !((m_fn >= 6) && !dp_peak && !m_first);
            if (m_re) m_first = 0;
            if (!m_go && m_re && !per_word(m_fn)) m_active = 0;
            m_proc = 0;
            m_out = m_go;
        end else if (m_out) begin
            m_out = 0;
            if (m_wcnt == 0) m_active = 0;
        end else if (exp_we()) begin
            if (!m_active) begin
                m_fn = fn_sel;
                m_active = 1;
            end
            m_bcnt++;
            if (m_bcnt == 16) begin
                m_bcnt = 0;
                m_proc = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_proc | m_out);
        chk("valid", valid, m_out);
        chk("dp_en", dp_en, m_proc);
        chk("acc_load", acc_load, m_proc && (m_wcnt == 0));
        chk("byte_we", byte_we, exp_we());
        chk("byte_cnt", byte_cnt, m_bcnt);
        chk("word_cnt", word_cnt, m_wcnt);
        chk("fn_q", fn_q, m_fn);
        if (rst) begin
            n_valid += int'(valid);
            n_dp += int'(dp_en);
            n_acc += int'(acc_load);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input logic [2:0] f);
        for (int i = 0; i < n; i++) begin
            in_en = 1'b1;
            fn_sel = f;
            step();
        end
        in_en = 1'b0;
    endtask

    task automatic idle(input int n);
        in_en = 1'b0;
        repeat (n) step();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and releases after the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        in_en = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_dp_en", dp_en, 0);
        chk("rst_acc_load", acc_load, 0);
        chk("rst_byte_we", byte_we, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_fn_q", fn_q, 0);
        step();
        rst = 1'b1;
    endtask

    int v0, d0, a0;
    int exp_rnd[3] = '{1, 0, 1};
    logic [2:0] m_pat;

    initial begin
        step();
        do_reset();

        // fn=0 while idle is ignored
        feed(3, 3'd0);
        chk("fn0_ignored_bytes", byte_cnt, 0);

        // fn=1, full round, latency of dp_en and valid
        do_reset();
        v0 = n_valid; d0 = n_dp; a0 = n_acc;
        for (int w = 0; w < 7; w++) begin
            feed(16, 3'd1);
            idle(1);
        end
        feed(16, 3'd1);
        chk("lat_dp_en", dp_en, 1);
        step();
        chk("lat_valid", valid, 1);
        step();
        chk("round_end_busy", busy, 0);
        step();
        chk("fn1_dp_count", n_dp - d0, 8);
        chk("fn1_acc_count", n_acc - a0, 1);
        chk("fn1_valid_count", n_valid - v0, 1);

        // fn=4, per-word matches 1,0,1
        do_reset();
        v0 = n_valid;
        m_pat = 3'b101;
        for (int w = 0; w < 3; w++) begin
            dp_match = m_pat[w];
            feed(16, 3'd4);
            idle(2);
        end
        dp_match = 1'b0;
        chk("fn4_valid_count", n_valid - v0, 2);
        chk("fn4_word_cnt", word_cnt, 3);

        // bytes offered while busy are dropped
        do_reset();
        dp_match = 1'b1;
        feed(19, 3'd4);
        dp_match = 1'b0;
        chk("drop_byte_cnt", byte_cnt, 1);
        chk("drop_word_cnt", word_cnt, 1);

        // fn=6 peak rounds: first always outputs, then only on dp_peak
        do_reset();
        for (int r = 0; r < 3; r++) begin
            dp_peak = (r == 2);
            v0 = n_valid;
            for (int w = 0; w < 8; w++) begin
                feed(16, 3'd6);
                idle(2);
            end
            chk("fn6_round_valid", n_valid - v0, exp_rnd[r]);
        end
        dp_peak = 1'b0;

        // reset at byte 9 of word 5 discards the round
        do_reset();
        for (int w = 0; w < 4; w++) begin
            feed(16, 3'd1);
            idle(1);
        end
        feed(8, 3'd1);
        v0 = n_valid;
        do_reset();
        for (int w = 0; w < 8; w++) begin
            feed(16, 3'd1);
            idle(2);
        end
        chk("post_reset_valid_count", n_valid - v0, 1);

        // fn_sel change mid-round has no effect until the next start
        do_reset();
        feed(1, 3'd1);
        feed(15, 3'd2);
        idle(1);
        for (int w = 0; w < 6; w++) begin
            feed(16, 3'd2);
            idle(1);
        end
        feed(16, 3'd2);
        step();
        chk("fn_hold_valid", valid, 1);
        chk("fn_hold_fn_q", fn_q, 1);
        step();
        feed(1, 3'd2);
        chk("fn_relatch", fn_q, 2);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            in_en = ($urandom_range(0, 3) != 0);
            fn_sel = 3'($urandom_range(0, 7));
            dp_match = 1'($urandom_range(0, 1));
            dp_peak = 1'($urandom_range(0, 1));
            step();
        end
        in_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
